// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: turns a valid/ready command stream into single AHB-Lite transfers,
// overlapping address and data phases and replaying a transfer cancelled by an ERROR response.
module ahb_lite_cmd_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PIPELINE = 1
) (
  input  logic              pad_core_clk,
  input  logic              pad_core_rst_b,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [3:0]        cmd_prot,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [2:0]        hsize,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  output logic              hwrite,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_ERR_WAIT = 2'd1;
  localparam logic [1:0] ST_REPLAY   = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  function automatic logic cmd_legal(input logic [2:0] size, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = ~({ADDR_W{1'b1}} << size);
    return (int'(size) <= MAX_SIZE) && ((addr & mask) == '0);
  endfunction

  logic [1:0]        state;
  logic              rdy_en;
  logic              a_vld;
  logic              d_vld;
  logic              replay;
  logic [DATA_W-1:0] wdata_p0;
  logic              write_p1;

  logic legal;
  logic accept;
  logic acc_legal;
  logic acc_illegal;
  logic a_done;
  logic d_done;
  logic err_first;
  logic err_last;

  assign legal       = cmd_legal(cmd_size, cmd_addr);
  assign accept      = cmd_vld && cmd_rdy;
  assign acc_legal   = accept && legal;
  assign acc_illegal = accept && !legal;
  assign a_done      = a_vld && hready;
  assign d_done      = d_vld && hready;
  assign err_first   = (state == ST_RUN) && d_vld && hresp && !hready;
  assign err_last    = (state == ST_ERR_WAIT) && hready && hresp;

  assign hburst = 3'b000;

  // Illegal commands never touch the bus, so they wait for it to drain completely.
  always_comb begin
    cmd_rdy = 1'b0;
    if (rdy_en && state == ST_RUN) begin
      if (legal && PIPELINE != 0) cmd_rdy = !a_vld || hready;
      else                        cmd_rdy = !a_vld && !d_vld;
    end
  end

  always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
    if (!pad_core_rst_b) begin
      state     <= ST_RUN;
      rdy_en    <= 1'b0;
      a_vld     <= 1'b0;
      d_vld     <= 1'b0;
      replay    <= 1'b0;
      haddr     <= '0;
      hprot     <= 4'b0011;
      hsize     <= 3'b010;
      htrans    <= HTRANS_IDLE;
      hwdata    <= '0;
      hwrite    <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rdy_en  <= 1'b1;
      rsp_vld <= 1'b0;

      // Address phase: haddr/hsize/hprot/hwrite double as the replay hold register
      if (acc_legal) begin
        haddr  <= cmd_addr;
        hsize  <= cmd_size;
        hprot  <= cmd_prot;
        hwrite <= cmd_write;
        htrans <= HTRANS_NONSEQ;
        a_vld  <= 1'b1;
      end else if (a_done) begin
        htrans <= HTRANS_IDLE;
        a_vld  <= 1'b0;
      end else if (err_first && a_vld) begin
        htrans <= HTRANS_IDLE;
        a_vld  <= 1'b0;
      end else if (err_last && replay) begin
        htrans <= HTRANS_NONSEQ;
        a_vld  <= 1'b1;
      end

      // Data phase
      if (a_done) begin
        d_vld <= 1'b1;
        if (hwrite) hwdata <= wdata_p0;
      end else if (d_done) begin
        d_vld <= 1'b0;
      end

      // Response
      if (d_done) begin
        rsp_vld   <= 1'b1;
        rsp_err   <= hresp;
        rsp_rdata <= write_p1 ? '0 : hrdata;
      end else if (acc_illegal) begin
        rsp_vld   <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end

      case (state)
        ST_RUN: begin
          if (err_first) begin
            state  <= ST_ERR_WAIT;
            replay <= a_vld;
          end
        end
        ST_ERR_WAIT: begin
          if (hready && hresp) state <= replay ? ST_REPLAY : ST_RUN;
        end
        default: begin
          state  <= ST_RUN;
          replay <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pad_core_clk) begin
    if (acc_legal) wdata_p0 <= cmd_wdata;
    if (a_done)    write_p1 <= hwrite;
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: pipelined and non-pipelined instances, scoreboarded responses.
module tb_ahb_lite_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Pipelined instance
  logic        cmd_vld = 1'b0, cmd_write = 1'b0, cmd_rdy;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = 3'd2;
  logic [3:0]  cmd_prot = 4'd3;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1, hresp = 1'b0;

  // Non-pipelined instance
  logic        cmd_vld0 = 1'b0, cmd_rdy0;
  logic [31:0] cmd_addr0 = '0;
  logic        rsp_vld0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [31:0] haddr0, hwdata0;
  logic [2:0]  hburst0, hsize0;
  logic [3:0]  hprot0;
  logic [1:0]  htrans0;
  logic        hwrite0;
  logic [31:0] hrdata0;
  logic [31:0] d_addr0 = '0;
  logic        dph0 = 1'b0;
  logic        busy0;

  ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .PIPELINE(1)) dut (
    .pad_core_clk(clk), .pad_core_rst_b(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hburst(hburst), .hprot(hprot), .hsize(hsize), .htrans(htrans),
    .hwdata(hwdata), .hwrite(hwrite), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .PIPELINE(0)) dut0 (
    .pad_core_clk(clk), .pad_core_rst_b(rst_n),
    .cmd_vld(cmd_vld0), .cmd_rdy(cmd_rdy0), .cmd_write(1'b0), .cmd_addr(cmd_addr0),
    .cmd_size(3'd2), .cmd_prot(4'd3), .cmd_wdata(32'h0),
    .rsp_vld(rsp_vld0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .haddr(haddr0), .hburst(hburst0), .hprot(hprot0), .hsize(hsize0), .htrans(htrans0),
    .hwdata(hwdata0), .hwrite(hwrite0), .hrdata(hrdata0), .hready(1'b1), .hresp(1'b0)
  );

  // Zero-wait slave for the non-pipelined instance: read data derived from the data-phase address
  always @(posedge clk) begin
    dph0 <= (htrans0 == 2'b10);
    if (htrans0 == 2'b10) d_addr0 <= haddr0;
  end
  assign hrdata0 = d_addr0 ^ 32'hA5A5_0000;
  assign busy0   = (htrans0 == 2'b10) || dph0;

  rsp_t q1[$];
  rsp_t q0[$];
  int checks = 0;
  int errors = 0;
  int n1 = 0;
  int n0 = 0;

  function automatic rsp_t mk(input logic [31:0] rd, input logic er);
    rsp_t r;
    r.rdata = rd;
    r.err   = er;
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: sample 1ns after the edge and score any response against the queues
  task automatic cyc();
    rsp_t e;
    @(posedge clk);
    #1;
    if (rsp_vld === 1'b1) begin
      n1++;
      if (q1.size() == 0) chk1("rsp1_unexpected", rsp_vld, 1'b0);
      else begin
        e = q1.pop_front();
        chk32("rsp1_rdata", rsp_rdata, e.rdata);
        chk1("rsp1_err", rsp_err, e.err);
      end
    end
    if (rsp_vld0 === 1'b1) begin
      n0++;
      if (q0.size() == 0) chk1("rsp0_unexpected", rsp_vld0, 1'b0);
      else begin
        e = q0.pop_front();
        chk32("rsp0_rdata", rsp_rdata0, e.rdata);
        chk1("rsp0_err", rsp_err0, e.err);
      end
    end
  endtask

  task automatic set_cmd(input logic vld, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [3:0] prot, input logic [31:0] wd);
    cmd_vld   = vld;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_prot  = prot;
    cmd_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx;
    logic acc;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk32("rst_haddr", haddr, 32'h0);
    chk32("rst_hburst", 32'(hburst), 32'h0);
    chk32("rst_hprot", 32'(hprot), 32'h3);
    chk32("rst_hsize", 32'(hsize), 32'h2);
    chk32("rst_htrans", 32'(htrans), 32'h0);
    chk32("rst_hwdata", hwdata, 32'h0);
    chk1("rst_hwrite", hwrite, 1'b0);
    chk1("rst_rsp_vld", rsp_vld, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk1("rst_cmd_rdy0", cmd_rdy0, 1'b0);
    chk32("rst0_bus", {haddr0[15:0], 1'b0, hburst0, hprot0, hsize0, htrans0, hwrite0},
          {16'h0, 1'b0, 3'b000, 4'b0011, 3'b010, 2'b00, 1'b0});
    chk32("rst0_hwdata", hwdata0, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Test 1: single write, zero wait
    set_cmd(1'b1, 1'b1, 32'h2000_0000, 3'd2, 4'b1010, 32'hDEAD_BEEF);
    chk1("t1_cmd_rdy", cmd_rdy, 1'b1);
    q1.push_back(mk(32'h0, 1'b0));
    cyc();
    cmd_vld = 1'b0;
    chk32("t1_htrans", 32'(htrans), 32'h2);
    chk32("t1_haddr", haddr, 32'h2000_0000);
    chk1("t1_hwrite", hwrite, 1'b1);
    chk32("t1_hprot", 32'(hprot), 32'hA);
    chk32("t1_hburst", 32'(hburst), 32'h0);
    cyc();
    chk32("t1_htrans_idle", 32'(htrans), 32'h0);
    chk32("t1_hwdata", hwdata, 32'hDEAD_BEEF);
    chk1("t1_rsp_early", rsp_vld, 1'b0);
    cyc();
    chk1("t1_rsp_vld", rsp_vld, 1'b1);

    // Test 2: back-to-back reads, 3 wait states on the first
    set_cmd(1'b1, 1'b0, 32'h100, 3'd2, 4'd3, 32'h0);
    q1.push_back(mk(32'h11, 1'b0));
    cyc();
    set_cmd(1'b1, 1'b0, 32'h104, 3'd2, 4'd3, 32'h0);
    chk1("t2_rdy_pipe", cmd_rdy, 1'b1);
    q1.push_back(mk(32'h22, 1'b0));
    cyc();
    cmd_vld = 1'b0;
    chk32("t2_htrans_b", 32'(htrans), 32'h2);
    chk32("t2_haddr_b", haddr, 32'h104);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk32("t2_hold_htrans", 32'(htrans), 32'h2);
      chk32("t2_hold_haddr", haddr, 32'h104);
      chk1("t2_wait_rdy", cmd_rdy, 1'b0);
      chk1("t2_wait_rsp", rsp_vld, 1'b0);
    end
    hready = 1'b1;
    hrdata = 32'h11;
    cyc();
    chk1("t2_rsp_a", rsp_vld, 1'b1);
    chk32("t2_htrans_idle", 32'(htrans), 32'h0);
    hrdata = 32'h22;
    cyc();
    chk1("t2_rsp_b", rsp_vld, 1'b1);
    hrdata = 32'h0;
    cyc();

    // Test 3: ERROR on a write with a pipelined read behind it
    set_cmd(1'b1, 1'b1, 32'h1F0, 3'd2, 4'd3, 32'h55);
    q1.push_back(mk(32'h0, 1'b1));
    cyc();
    set_cmd(1'b1, 1'b0, 32'h200, 3'd2, 4'd3, 32'h0);
    q1.push_back(mk(32'h33, 1'b0));
    cyc();
    cmd_vld = 1'b0;
    chk32("t3_htrans_r", 32'(htrans), 32'h2);
    hready = 1'b0;
    hresp  = 1'b1;
    cyc();
    chk32("t3_cancel", 32'(htrans), 32'h0);
    chk1("t3_err_rdy", cmd_rdy, 1'b0);
    chk1("t3_err_rsp_early", rsp_vld, 1'b0);
    hready = 1'b1;
    cyc();
    chk1("t3_err_rsp", rsp_vld, 1'b1);
    chk32("t3_replay_htrans", 32'(htrans), 32'h2);
    chk32("t3_replay_haddr", haddr, 32'h200);
    chk1("t3_replay_hwrite", hwrite, 1'b0);
    chk1("t3_replay_rdy", cmd_rdy, 1'b0);
    hresp = 1'b0;
    cyc();
    chk32("t3_replay_done", 32'(htrans), 32'h0);
    chk1("t3_no_rsp", rsp_vld, 1'b0);
    hrdata = 32'h33;
    cyc();
    chk1("t3_read_rsp", rsp_vld, 1'b1);
    hrdata = 32'h0;
    cyc();
    cyc();
    chk32("t3_drain", 32'(q1.size()), 32'h0);

    // Test 4: illegal commands (misaligned halfword, oversize)
    set_cmd(1'b1, 1'b0, 32'h1, 3'd1, 4'd3, 32'h0);
    chk1("t4_rdy", cmd_rdy, 1'b1);
    q1.push_back(mk(32'h0, 1'b1));
    cyc();
    cmd_vld = 1'b0;
    chk1("t4_rsp", rsp_vld, 1'b1);
    chk32("t4_no_bus", 32'(htrans), 32'h0);
    cyc();
    chk32("t4_no_bus2", 32'(htrans), 32'h0);
    chk1("t4_rsp_once", rsp_vld, 1'b0);
    set_cmd(1'b1, 1'b0, 32'h0, 3'd3, 4'd3, 32'h0);
    q1.push_back(mk(32'h0, 1'b1));
    cyc();
    cmd_vld = 1'b0;
    chk1("t4_size_rsp", rsp_vld, 1'b1);
    chk32("t4_size_no_bus", 32'(htrans), 32'h0);
    cyc();

    // Sustained one-per-cycle throughput on the pipelined instance
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        set_cmd(1'b1, 1'b0, 32'h600 + 32'(k) * 4, 3'd2, 4'd3, 32'h0);
        chk1("t7_rdy", cmd_rdy, 1'b1);
        q1.push_back(mk(32'hA000_0000 + 32'(k), 1'b0));
      end else begin
        cmd_vld = 1'b0;
      end
      hrdata = (k >= 2) ? 32'hA000_0000 + 32'(k - 2) : 32'h0;
      cyc();
      if (k >= 2) chk1("t7_rsp", rsp_vld, 1'b1);
    end
    cyc();

    // Test 6: non-pipelined instance, 4 consecutive reads
    idx = 0;
    for (int c = 0; c < 30 && n0 < 4; c++) begin
      cmd_vld0  = (idx < 4);
      cmd_addr0 = 32'h40 + 32'(idx) * 16;
      chk1("t6_rdy", cmd_rdy0, !busy0);
      acc = cmd_vld0 && cmd_rdy0;
      if (acc) q0.push_back(mk((32'h40 + 32'(idx) * 16) ^ 32'hA5A5_0000, 1'b0));
      cyc();
      if (acc) idx++;
    end
    cmd_vld0 = 1'b0;
    chk32("t6_count", 32'(n0), 32'd4);

    // Test 5: reset during a data phase with wait states
    set_cmd(1'b1, 1'b0, 32'h401, 3'd0, 4'hF, 32'h0);
    chk1("t5_rdy", cmd_rdy, 1'b1);
    cyc();
    cmd_vld = 1'b0;
    cyc();
    hready = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk32("t5_htrans", 32'(htrans), 32'h0);
    chk32("t5_haddr", haddr, 32'h0);
    chk32("t5_hsize", 32'(hsize), 32'h2);
    chk32("t5_hprot", 32'(hprot), 32'h3);
    chk32("t5_hwdata", hwdata, 32'h0);
    chk1("t5_rsp_vld", rsp_vld, 1'b0);
    chk1("t5_cmd_rdy", cmd_rdy, 1'b0);
    cyc();
    hready = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("t5_no_rsp", rsp_vld, 1'b0);
    end
    set_cmd(1'b1, 1'b0, 32'h500, 3'd2, 4'd3, 32'h0);
    chk1("t5_rdy_after", cmd_rdy, 1'b1);
    q1.push_back(mk(32'h77, 1'b0));
    cyc();
    cmd_vld = 1'b0;
    chk32("t5_htrans_after", 32'(htrans), 32'h2);
    cyc();
    hrdata = 32'h77;
    cyc();
    chk1("t5_rsp_after", rsp_vld, 1'b1);
    cyc();

    chk32("q1_drain", 32'(q1.size()), 32'h0);
    chk32("q0_drain", 32'(q0.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
